// File: rtl/popcount_seq_ctrl_if.sv
// Handshake bundle for the sequential popcount controller: vector input
// channel (data + threshold) and result output channel.
interface popcount_seq_ctrl_if #(
    parameter int DATA_W = 1024,
    parameter int CNT_W  = $clog2(DATA_W) + 1
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CNT_W-1:0]  thresh;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_ge;

    modport master (
        output in_valid, in_data, thresh, out_ready,
        input  in_ready, out_valid, out_count, out_ge
    );

    modport slave (
        input  in_valid, in_data, thresh, out_ready,
        output in_ready, out_valid, out_count, out_ge
    );
endinterface

// File: rtl/popcount_seq_ctrl.sv
// Counts the 1's of a DATA_W-bit vector by walking one SLICE_W-bit popcount
// slice across it, one slice per clock, then hands out the total and a >= flag.
module popcount_seq_ctrl #(
    parameter int DATA_W  = 1024,
    parameter int SLICE_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    popcount_seq_ctrl_if.slave bus,
    output logic              busy
);
    localparam int N_SLICE = DATA_W / SLICE_W;
    localparam int CNT_W   = $clog2(DATA_W) + 1;
    localparam int IDX_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
    localparam int PC_W    = $clog2(SLICE_W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   thr_q;
    logic [CNT_W-1:0]   acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   count_q;
    logic               ge_q;

    logic [SLICE_W-1:0] slice;
    logic [PC_W-1:0]    slice_pc;
    logic [CNT_W-1:0]   sum_next;
    logic               last_slice;

    assign slice      = data_q[idx_q*SLICE_W +: SLICE_W];
    assign last_slice = (idx_q == IDX_W'(N_SLICE - 1));
    assign sum_next   = acc_q + CNT_W'(slice_pc);

    // NOTE: blocking '=' is correct here -- each iteration must see the running
    // sum of the previous one; sequential state below uses '<=' only.
    always_comb begin
        slice_pc = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            slice_pc = slice_pc + PC_W'(slice[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_slice) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort outranks every transition, including an accept in IDLE.
        if (clr) state_d = IDLE;
    end

    // NOTE: the wide data register is reset along with the rest of the
    // datapath, so nothing observable after reset can derive from stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            thr_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            ge_q    <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q <= bus.in_data;
                        thr_q  <= bus.thresh;
                        acc_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                RUN: begin
                    acc_q <= sum_next;
                    if (last_slice) begin
                        idx_q   <= '0;
                        count_q <= sum_next;
                        ge_q    <= (sum_next >= thr_q);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_count = count_q;
    assign bus.out_ge    = ge_q;
endmodule
